// File: rtl/btb_next_pc.sv
// Tagged branch target buffer supplying the fetch stage's next PC, with a hardware clear sweep.
// Optional BTB_HYST_EN: 2-bit saturating direction counters (default build: 1-bit direction).
module btb_next_pc #(
    parameter int unsigned DBITS = 16,
    parameter int unsigned ABITS = 8,
    parameter int unsigned INCR  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DBITS-1:0] pc,
    output logic [DBITS-1:0] pred_npc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic             ready,
    input  logic             upd_en,
    input  logic [DBITS-1:0] upd_pc,
    input  logic             upd_taken,
    input  logic [DBITS-1:0] upd_target,
    input  logic             inv_all
);

    localparam int unsigned DEPTH = 1 << ABITS;
    localparam int unsigned TAG_W = DBITS - ABITS - 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ABITS-1:0] clear_idx;
    logic [ABITS-1:0] clear_idx_nxt;

    logic [DEPTH-1:0] valid;
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [DBITS-1:0] tgt_mem [DEPTH];
    logic [1:0]       ctr_mem [DEPTH];

    logic [ABITS-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [ABITS-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic [1:0]       up_ctr;
    logic [1:0]       ctr_nxt;
    logic             up_hit;
    logic             do_upd;
    logic             do_alloc;
    logic             do_train;
    logic             unused_bits;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_CLEAR;
            clear_idx <= '0;
        end else begin
            state     <= state_nxt;
            clear_idx <= clear_idx_nxt;
        end
    end

    // Next-state: sweep every index once, inv_all (re)starts the sweep at 0
    always_comb begin
        state_nxt     = state;
        clear_idx_nxt = clear_idx;
        case (state)
            ST_CLEAR: begin
                if (inv_all) begin
                    clear_idx_nxt = '0;
                end else begin
                    clear_idx_nxt = clear_idx + ABITS'(1);
                    if (clear_idx == ABITS'(DEPTH - 1)) begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (inv_all) begin
                    state_nxt     = ST_CLEAR;
                    clear_idx_nxt = '0;
                end
            end
            default: begin
                state_nxt     = ST_CLEAR;
                clear_idx_nxt = '0;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        ready = 1'b0;
        if (state == ST_RUN) begin
            ready = 1'b1;
        end
    end

    // Combinational lookup; no bypass of a same-cycle update
    always_comb begin
        lk_idx     = pc[ABITS:1];
        lk_tag     = pc[DBITS-1:ABITS+1];
        pred_hit   = ready & valid[lk_idx] & (tag_mem[lk_idx] == lk_tag);
        pred_taken = pred_hit & ctr_mem[lk_idx][1];
        pred_npc   = pred_taken ? tgt_mem[lk_idx] : (pc + DBITS'(INCR));
    end

    // Update decode and direction training
    always_comb begin
        up_idx   = upd_pc[ABITS:1];
        up_tag   = upd_pc[DBITS-1:ABITS+1];
        up_ctr   = ctr_mem[up_idx];
        up_hit   = valid[up_idx] & (tag_mem[up_idx] == up_tag);
        do_upd   = upd_en & ready & ~inv_all;
        do_alloc = do_upd & ~up_hit & upd_taken;
        do_train = do_upd & up_hit;
`ifdef BTB_HYST_EN
        ctr_nxt = up_ctr;
        if (upd_taken) begin
            if (up_ctr != 2'b11) begin
                ctr_nxt = up_ctr + 2'd1;
            end
        end else begin
            if (up_ctr != 2'b00) begin
                ctr_nxt = up_ctr - 2'd1;
            end
        end
`else
        ctr_nxt = {upd_taken, 1'b0};
`endif
    end

    assign unused_bits = ^{pc[0], upd_pc[0], up_ctr};

    // Valid bits: the only table state touched by reset and the sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (state == ST_CLEAR) begin
            valid[clear_idx] <= 1'b0;
        end else if (do_alloc) begin
            valid[up_idx] <= 1'b1;
        end
    end

    // Entry payload, qualified by valid so it needs no reset
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            tag_mem[up_idx] <= up_tag;
            tgt_mem[up_idx] <= upd_target;
            ctr_mem[up_idx] <= 2'b10;
        end else if (do_train) begin
            ctr_mem[up_idx] <= ctr_nxt;
            if (upd_taken) begin
                tgt_mem[up_idx] <= upd_target;
            end
        end
    end

endmodule

// File: tb/tb_btb_next_pc.sv
// Self-checking bench for btb_next_pc: directed scenarios plus randomized traffic against a table model.
module tb_btb_next_pc;

    localparam int DEPTH = 256;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc;
    logic [15:0] pred_npc;
    logic        pred_hit;
    logic        pred_taken;
    logic        ready;
    logic        upd_en;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        inv_all;
    logic [18:0] obs;

    int checks;
    int failures;

    btb_next_pc #(.DBITS(16), .ABITS(8), .INCR(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .pred_npc   (pred_npc),
        .pred_hit   (pred_hit),
        .pred_taken (pred_taken),
        .ready      (ready),
        .upd_en     (upd_en),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target),
        .inv_all    (inv_all)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {ready, pred_hit, pred_taken, pred_npc};

    typedef struct {
        bit        v;
        bit [6:0]  tag;
        bit [15:0] tgt;
        int        ctr;
    } ent_t;

    ent_t m_tab [DEPTH];
    int   m_clr;

    function automatic void m_reset();
        m_clr = DEPTH;
        for (int i = 0; i < DEPTH; i++) m_tab[i].v = 1'b0;
    endfunction

    // Reference model: one call per clock edge with the inputs present at that edge
    function automatic void m_update(bit en, bit [15:0] upc, bit tk, bit [15:0] tgt, bit inv);
        int i;
        if (inv) begin
            m_reset();
            return;
        end
        if (m_clr > 0) begin
            m_clr--;
            return;
        end
        if (!en) return;
        i = int'(upc[8:1]);
        if (m_tab[i].v && m_tab[i].tag == upc[15:9]) begin
`ifdef BTB_HYST_EN
            if (tk) m_tab[i].ctr = (m_tab[i].ctr < 3) ? m_tab[i].ctr + 1 : 3;
            else    m_tab[i].ctr = (m_tab[i].ctr > 0) ? m_tab[i].ctr - 1 : 0;
`else
            m_tab[i].ctr = tk ? 2 : 0;
`endif
            if (tk) m_tab[i].tgt = tgt;
        end else if (tk) begin
            m_tab[i].v   = 1'b1;
            m_tab[i].tag = upc[15:9];
            m_tab[i].tgt = tgt;
            m_tab[i].ctr = 2;
        end
    endfunction

    function automatic logic [18:0] m_expect(logic [15:0] p);
        int          i;
        bit          r;
        bit          h;
        bit          tk;
        logic [15:0] n;
        i  = int'(p[8:1]);
        r  = (m_clr == 0);
        h  = r && m_tab[i].v && (m_tab[i].tag == p[15:9]);
        tk = h && (m_tab[i].ctr >= 2);
        n  = tk ? m_tab[i].tgt : 16'(p + 16'd2);
        return {r, h, tk, n};
    endfunction

    task automatic tick();
        bit        e;
        bit        t;
        bit        iv;
        bit [15:0] p;
        bit [15:0] g;
        e = upd_en; p = upd_pc; t = upd_taken; g = upd_target; iv = inv_all;
        @(posedge clk);
        m_update(e, p, t, g, iv);
        #1;
    endtask

    task automatic set_upd(bit en, bit [15:0] p, bit t, bit [15:0] g);
        upd_en = en; upd_pc = p; upd_taken = t; upd_target = g;
    endtask

    task automatic test_reset();
        int n;
        pc = 16'h0200; set_upd(0, 0, 0, 0); inv_all = 0;
        rst_n = 0;
        m_reset();
        #3;
        checks++;
        if (obs !== {3'b000, 16'h0202}) begin
            failures++; $display("FAIL reset_state: got %h expected %h", obs, {3'b000, 16'h0202});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        n = 0;
        while (ready !== 1'b1 && n < 300) begin
            checks++;
            if (obs !== {3'b000, 16'h0202} || obs !== m_expect(pc)) begin
                failures++; $display("FAIL reset_sweep: cyc %0d got %h expected %h", n, obs, {3'b000, 16'h0202});
            end
            tick(); n++;
        end
        checks++;
        if (n != 256) begin
            failures++; $display("FAIL reset_sweep_len: got %0d expected 256", n);
        end
    endtask

    task automatic test_alloc();
        pc = 16'h0000; set_upd(1, 16'h0210, 1, 16'h0240);
        tick();
        upd_en = 0; pc = 16'h0210; #1;
        checks++;
        if (obs !== {3'b111, 16'h0240} || obs !== m_expect(pc)) begin
            failures++; $display("FAIL alloc_hit: got %h expected %h", obs, {3'b111, 16'h0240});
        end
        set_upd(1, 16'h0210, 0, 16'h0000);
        tick();
        upd_en = 0; #1;
        checks++;
        if (obs !== {3'b110, 16'h0212} || obs !== m_expect(pc)) begin
            failures++; $display("FAIL alloc_nt: got %h expected %h", obs, {3'b110, 16'h0212});
        end
    endtask

    task automatic test_alias();
        pc = 16'h0410; #1;
        checks++;
        if (obs !== {3'b100, 16'h0412} || obs !== m_expect(pc)) begin
            failures++; $display("FAIL alias_miss: got %h expected %h", obs, {3'b100, 16'h0412});
        end
        set_upd(1, 16'h0410, 0, 16'h0777);
        tick();
        upd_en = 0; pc = 16'h0210; #1;
        checks++;
        if (obs !== {3'b110, 16'h0212} || obs !== m_expect(pc)) begin
            failures++; $display("FAIL alias_keep: got %h expected %h", obs, {3'b110, 16'h0212});
        end
    endtask

    task automatic test_saturation();
        pc = 16'h0210;
        set_upd(1, 16'h0210, 1, 16'h0240);
        repeat (5) tick();
        upd_en = 0; #1;
        checks++;
        if (obs !== {3'b111, 16'h0240} || obs !== m_expect(pc)) begin
            failures++; $display("FAIL sat_taken: got %h expected %h", obs, {3'b111, 16'h0240});
        end
        set_upd(1, 16'h0210, 0, 16'h0000);
        tick();
        upd_en = 0; #1;
        checks++;
        if (obs !== m_expect(pc)) begin
            failures++; $display("FAIL sat_nt1: got %h expected %h", obs, m_expect(pc));
        end
        upd_en = 1;
        tick();
        upd_en = 0; #1;
        checks++;
        if (obs !== {3'b110, 16'h0212} || obs !== m_expect(pc)) begin
            failures++; $display("FAIL sat_nt2: got %h expected %h", obs, {3'b110, 16'h0212});
        end
    endtask

    task automatic test_same_cycle();
        pc = 16'h0300; set_upd(1, 16'h0300, 1, 16'h0100); #1;
        checks++;
        if (obs !== {3'b100, 16'h0302} || obs !== m_expect(pc)) begin
            failures++; $display("FAIL same_cycle_pre: got %h expected %h", obs, {3'b100, 16'h0302});
        end
        tick();
        upd_en = 0; #1;
        checks++;
        if (obs !== {3'b111, 16'h0100} || obs !== m_expect(pc)) begin
            failures++; $display("FAIL same_cycle_post: got %h expected %h", obs, {3'b111, 16'h0100});
        end
    endtask

    task automatic test_wrap();
        pc = 16'hFFFE; #1;
        checks++;
        if (obs !== {3'b100, 16'h0000} || obs !== m_expect(pc)) begin
            failures++; $display("FAIL wrap: got %h expected %h", obs, {3'b100, 16'h0000});
        end
    endtask

    task automatic test_random();
        logic [15:0] pool [8];
        pool[0] = 16'h0210; pool[1] = 16'h0410; pool[2] = 16'h0300; pool[3] = 16'h1300;
        pool[4] = 16'hFFFE; pool[5] = 16'h0000; pool[6] = 16'h8212; pool[7] = 16'h0212;
        for (int k = 0; k < 500; k++) begin
            pc = pool[$urandom_range(0, 7)];
            set_upd(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)],
                    1'($urandom_range(0, 1)), 16'($urandom));
            #1;
            checks++;
            if (obs !== m_expect(pc)) begin
                failures++; $display("FAIL random: step %0d pc %h got %h expected %h", k, pc, obs, m_expect(pc));
            end
            tick();
        end
        upd_en = 0;
    endtask

    task automatic test_inv_all();
        int n;
        pc = 16'h0500; set_upd(1, 16'h0500, 1, 16'h0600); inv_all = 1;
        tick();
        inv_all = 0; upd_en = 0;
        for (int k = 0; k < 50; k++) begin
            checks++;
            if (obs !== {3'b000, 16'h0502} || obs !== m_expect(pc)) begin
                failures++; $display("FAIL inv_sweep: cyc %0d got %h expected %h", k, obs, {3'b000, 16'h0502});
            end
            tick();
        end
        inv_all = 1;
        tick();
        inv_all = 0;
        n = 0;
        while (ready !== 1'b1 && n < 300) begin
            tick(); n++;
        end
        checks++;
        if (n != 256) begin
            failures++; $display("FAIL inv_restart_len: got %0d expected 256", n);
        end
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: pc = 16'h0210;
                1: pc = 16'h0300;
                2: pc = 16'h0500;
                default: pc = 16'h0410;
            endcase
            #1;
            checks++;
            if (obs !== {3'b100, 16'(pc + 16'd2)} || obs !== m_expect(pc)) begin
                failures++; $display("FAIL inv_miss: pc %h got %h expected %h", pc, obs, {3'b100, 16'(pc + 16'd2)});
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        pc = 16'h0210; set_upd(1, 16'h0210, 1, 16'h0240);
        tick();
        upd_en = 0; inv_all = 1;
        tick();
        inv_all = 0;
        repeat (100) tick();
        #2;
        rst_n = 0;
        m_reset();
        #1;
        checks++;
        if (obs !== {3'b000, 16'h0212}) begin
            failures++; $display("FAIL mid_reset: got %h expected %h", obs, {3'b000, 16'h0212});
        end
        #2;
        rst_n = 1;
        n = 0;
        while (ready !== 1'b1 && n < 300) begin
            tick(); n++;
        end
        checks++;
        if (n != 256) begin
            failures++; $display("FAIL mid_reset_len: got %0d expected 256", n);
        end
        checks++;
        if (obs !== {3'b100, 16'h0212} || obs !== m_expect(pc)) begin
            failures++; $display("FAIL mid_reset_miss: got %h expected %h", obs, {3'b100, 16'h0212});
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_alloc();
        test_alias();
        test_saturation();
        test_same_cycle();
        test_wrap();
        test_random();
        test_inv_all();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
